// File: rtl/mc8051_mem_arb_pkg.sv
// Shared constants and types for the mc8051 external memory arbiter.
// Holds the arbiter state encoding, requester IDs and bus widths, plus
// small helpers that convert between requester IDs and one-hot grants.
package mc8051_mem_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_WAIT   = 2'd1,
      ARB_ACCESS = 2'd2
   } arb_state_e;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_S2 = 2'd0;
   localparam req_id_t REQ_S3 = 2'd1;
   localparam req_id_t REQ_S5 = 2'd2;

   // Bit position in every 3-bit requester vector is the requester ID.
   function automatic logic [2:0] id_to_onehot(input req_id_t id);
      logic [2:0] oh;
      oh = 3'b000;
      case (id)
         REQ_S2:  oh = 3'b001;
         REQ_S3:  oh = 3'b010;
         REQ_S5:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   function automatic req_id_t onehot_to_id(input logic [2:0] oh);
      req_id_t id;
      id = REQ_S2;
      if (oh[REQ_S5])      id = REQ_S5;
      else if (oh[REQ_S3]) id = REQ_S3;
      return id;
   endfunction

endpackage

// File: rtl/mc8051_mem_arb_if.sv
// Bus bundle between the core pipeline stages, the arbiter and memory.
// Optional macro MC8051_MEM_TIMEOUT_EN adds the o_err timeout pulse.
interface mc8051_mem_arb_if;
   import mc8051_mem_arb_pkg::*;

   logic              i_s2_req;
   logic [ADDR_W-1:0] i_s2_addr;
   logic              i_s3_req;
   logic [ADDR_W-1:0] i_s3_addr;
   logic              i_s5_req;
   logic [ADDR_W-1:0] i_s5_addr;
   logic [DATA_W-1:0] i_s5_wdata;
   logic              o_s2_ack;
   logic              o_s3_ack;
   logic              o_s5_ack;
   logic [DATA_W-1:0] o_rdata;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              o_mem_rd;
   logic              o_mem_wr;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              i_mem_ready;
   logic              o_stall;
`ifdef MC8051_MEM_TIMEOUT_EN
   logic              o_err;
`endif

   // Arbiter side
   modport slave (
      input  i_s2_req, i_s2_addr, i_s3_req, i_s3_addr,
      input  i_s5_req, i_s5_addr, i_s5_wdata, i_mem_rdata, i_mem_ready,
      output o_s2_ack, o_s3_ack, o_s5_ack, o_rdata,
      output o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr, o_stall
`ifdef MC8051_MEM_TIMEOUT_EN
      , output o_err
`endif
   );

   // Core and memory side
   modport master (
      output i_s2_req, i_s2_addr, i_s3_req, i_s3_addr,
      output i_s5_req, i_s5_addr, i_s5_wdata, i_mem_rdata, i_mem_ready,
      input  o_s2_ack, o_s3_ack, o_s5_ack, o_rdata,
      input  o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr, o_stall
`ifdef MC8051_MEM_TIMEOUT_EN
      , input o_err
`endif
   );

endinterface

// File: rtl/mc8051_mem_arb_prio.sv
// Fixed-priority 3-way encoder: S5 beats S3 beats S2. Masked requesters
// are ignored so a stage whose ack is in flight cannot be granted twice.
module mc8051_mem_arb_prio
   import mc8051_mem_arb_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [2:0] mask_i,
   output logic [2:0] grant_o
);

   logic [2:0] availVec;

   // Pick the oldest pipeline stage among the unmasked requesters
   always_comb begin
      availVec = req_i & ~mask_i;
      grant_o  = 3'b000;
      if (availVec[REQ_S5])      grant_o[REQ_S5] = 1'b1;
      else if (availVec[REQ_S3]) grant_o[REQ_S3] = 1'b1;
      else if (availVec[REQ_S2]) grant_o[REQ_S2] = 1'b1;
   end

endmodule

// File: rtl/mc8051_mem_arb.sv
// mc8051 external memory arbiter: serialises S2/S3 reads and S5 writes
// onto the single memory port, inserts wait states, issues acks and the
// core stall. Optional macro MC8051_MEM_TIMEOUT_EN aborts accesses that
// see no i_mem_ready within TIMEOUT cycles and pulses o_err.
module mc8051_mem_arb
   import mc8051_mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
`ifdef MC8051_MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
)(
   input logic              i_clk,
   input logic              i_rst_n,
   mc8051_mem_arb_if.slave  bus
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef MC8051_MEM_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
`endif

   arb_state_e        state_q, state_d;
   req_id_t           win_q, win_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [2:0]        ack_q, ack_d;
   logic              stall_q, stall_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
`ifdef MC8051_MEM_TIMEOUT_EN
   logic [15:0]       to_cnt_q, to_cnt_d;
   logic              err_q, err_d;
`endif

   logic [2:0] reqVec;
   logic [2:0] grantVec;

   assign reqVec[REQ_S2] = bus.i_s2_req;
   assign reqVec[REQ_S3] = bus.i_s3_req;
   assign reqVec[REQ_S5] = bus.i_s5_req;

   mc8051_mem_arb_prio u_prio (
      .req_i   (reqVec),
      .mask_i  (ack_q),
      .grant_o (grantVec)
   );

   // Next-state decode: grant in IDLE, count wait states, complete on ready
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      ack_d      = 3'b000;
      wait_cnt_d = wait_cnt_q;
`ifdef MC8051_MEM_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (|grantVec) begin
               win_d = onehot_to_id(grantVec);
               if (grantVec[REQ_S5]) begin
                  addr_d  = bus.i_s5_addr;
                  wdata_d = bus.i_s5_wdata;
                  wr_d    = 1'b1;
               end else if (grantVec[REQ_S3]) begin
                  addr_d = bus.i_s3_addr;
                  rd_d   = 1'b1;
               end else begin
                  addr_d = bus.i_s2_addr;
                  rd_d   = 1'b1;
               end
               wait_cnt_d = WAIT_LOAD;
`ifdef MC8051_MEM_TIMEOUT_EN
               to_cnt_d   = 16'd0;
`endif
               state_d = (WAIT_CYCLES > 0) ? ARB_WAIT : ARB_ACCESS;
            end
         end
         ARB_WAIT: begin
            if (wait_cnt_q == 4'd0) state_d = ARB_ACCESS;
            else                    wait_cnt_d = wait_cnt_q - 4'd1;
         end
         ARB_ACCESS: begin
            if (bus.i_mem_ready) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               ack_d   = id_to_onehot(win_q);
               if (rd_q) rdata_d = bus.i_mem_rdata;
               state_d = ARB_IDLE;
            end
`ifdef MC8051_MEM_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               ack_d   = id_to_onehot(win_q);
               err_d   = 1'b1;
               if (rd_q) rdata_d = 8'hFF;
               state_d = ARB_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = ARB_IDLE;
      endcase
      stall_d = (state_d != ARB_IDLE) || (|(reqVec & ~ack_q));
   end

   // State and output registers, cleared immediately by reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ARB_IDLE;
         win_q      <= REQ_S2;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         ack_q      <= 3'b000;
         stall_q    <= 1'b0;
         wait_cnt_q <= 4'd0;
`ifdef MC8051_MEM_TIMEOUT_EN
         to_cnt_q   <= 16'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         ack_q      <= ack_d;
         stall_q    <= stall_d;
         wait_cnt_q <= wait_cnt_d;
`ifdef MC8051_MEM_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign bus.o_s2_ack    = ack_q[REQ_S2];
   assign bus.o_s3_ack    = ack_q[REQ_S3];
   assign bus.o_s5_ack    = ack_q[REQ_S5];
   assign bus.o_rdata     = rdata_q;
   assign bus.o_mem_addr  = addr_q;
   assign bus.o_mem_wdata = wdata_q;
   assign bus.o_mem_rd    = rd_q;
   assign bus.o_mem_wr    = wr_q;
   assign bus.o_stall     = stall_q;
`ifdef MC8051_MEM_TIMEOUT_EN
   assign bus.o_err       = err_q;
`endif

endmodule

// File: tb/tb_mc8051_mem_arb.sv
// Directed testbench for mc8051_mem_arb. bus0 drives a zero-wait-state
// arbiter, bus3 one with three wait states. With MC8051_MEM_TIMEOUT_EN
// defined, bus0's arbiter uses TIMEOUT=8 and the timeout scenario runs.
module tb_mc8051_mem_arb;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mc8051_mem_arb_if bus0();
   mc8051_mem_arb_if bus3();

   mc8051_mem_arb #(
      .WAIT_CYCLES(0)
`ifdef MC8051_MEM_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut0 (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .bus     (bus0.slave)
   );

   mc8051_mem_arb #(
      .WAIT_CYCLES(3)
`ifdef MC8051_MEM_TIMEOUT_EN
      , .TIMEOUT(64)
`endif
   ) dut3 (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .bus     (bus3.slave)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are sampled
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      bus0.i_s2_req = 0; bus0.i_s2_addr = '0; bus0.i_s3_req = 0; bus0.i_s3_addr = '0;
      bus0.i_s5_req = 0; bus0.i_s5_addr = '0; bus0.i_s5_wdata = '0;
      bus0.i_mem_rdata = '0; bus0.i_mem_ready = 0;
      bus3.i_s2_req = 0; bus3.i_s2_addr = '0; bus3.i_s3_req = 0; bus3.i_s3_addr = '0;
      bus3.i_s5_req = 0; bus3.i_s5_addr = '0; bus3.i_s5_wdata = '0;
      bus3.i_mem_rdata = '0; bus3.i_mem_ready = 0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      step(); step();
      checks++; if (bus0.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd: got %b expected 0", bus0.o_mem_rd); end
      checks++; if (bus0.o_mem_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr: got %b expected 0", bus0.o_mem_wr); end
      checks++; if ({bus0.o_s5_ack, bus0.o_s3_ack, bus0.o_s2_ack} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 000", {bus0.o_s5_ack, bus0.o_s3_ack, bus0.o_s2_ack}); end
      checks++; if (bus0.o_rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 00", bus0.o_rdata); end
      checks++; if (bus0.o_mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0000", bus0.o_mem_addr); end
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", bus0.o_stall); end
      checks++; if (bus3.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd3: got %b expected 0", bus3.o_mem_rd); end
      rstN = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      bus0.i_mem_ready = 1'b1;
      bus0.i_mem_rdata = 8'hA5;
      bus0.i_s2_addr   = 16'h0123;
      bus0.i_s2_req    = 1'b1;
      step();
      checks++; if (bus0.o_mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL single_rd: got %b expected 1", bus0.o_mem_rd); end
      checks++; if (bus0.o_mem_addr !== 16'h0123) begin failures++; $display("[TB] FAIL single_addr: got %h expected 0123", bus0.o_mem_addr); end
      checks++; if (bus0.o_s2_ack !== 1'b0) begin failures++; $display("[TB] FAIL single_early_ack: got %b expected 0", bus0.o_s2_ack); end
      checks++; if (bus0.o_stall !== 1'b1) begin failures++; $display("[TB] FAIL single_stall1: got %b expected 1", bus0.o_stall); end
      step();
      checks++; if (bus0.o_s2_ack !== 1'b1) begin failures++; $display("[TB] FAIL single_ack: got %b expected 1", bus0.o_s2_ack); end
      checks++; if (bus0.o_rdata !== 8'hA5) begin failures++; $display("[TB] FAIL single_rdata: got %h expected a5", bus0.o_rdata); end
      checks++; if (bus0.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL single_rd_drop: got %b expected 0", bus0.o_mem_rd); end
      checks++; if (bus0.o_stall !== 1'b1) begin failures++; $display("[TB] FAIL single_stall2: got %b expected 1", bus0.o_stall); end
      bus0.i_s2_req = 1'b0;
      step();
      checks++; if (bus0.o_s2_ack !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_pulse: got %b expected 0", bus0.o_s2_ack); end
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL single_stall_end: got %b expected 0", bus0.o_stall); end
   endtask

   task automatic test_back_to_back();
      bit         expRd    [7] = '{0, 0, 1, 0, 1, 0, 0};
      bit         expWr    [7] = '{1, 0, 0, 0, 0, 0, 0};
      bit         expStall [7] = '{1, 1, 1, 1, 1, 1, 0};
      logic [2:0] expAck   [7] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
      logic [15:0] expAddr [7] = '{16'h5555, 16'h0000, 16'h3333, 16'h0000, 16'h2222, 16'h0000, 16'h0000};
      logic [2:0] ackObs;
      bus0.i_mem_ready = 1'b1;
      bus0.i_mem_rdata = 8'h77;
      bus0.i_s2_addr = 16'h2222; bus0.i_s3_addr = 16'h3333;
      bus0.i_s5_addr = 16'h5555; bus0.i_s5_wdata = 8'h3C;
      bus0.i_s2_req = 1'b1; bus0.i_s3_req = 1'b1; bus0.i_s5_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         ackObs = {bus0.o_s5_ack, bus0.o_s3_ack, bus0.o_s2_ack};
         checks++; if (bus0.o_mem_rd !== expRd[i]) begin failures++; $display("[TB] FAIL b2b_rd[%0d]: got %b expected %b", i, bus0.o_mem_rd, expRd[i]); end
         checks++; if (bus0.o_mem_wr !== expWr[i]) begin failures++; $display("[TB] FAIL b2b_wr[%0d]: got %b expected %b", i, bus0.o_mem_wr, expWr[i]); end
         checks++; if (ackObs !== expAck[i]) begin failures++; $display("[TB] FAIL b2b_ack[%0d]: got %b expected %b", i, ackObs, expAck[i]); end
         checks++; if (bus0.o_stall !== expStall[i]) begin failures++; $display("[TB] FAIL b2b_stall[%0d]: got %b expected %b", i, bus0.o_stall, expStall[i]); end
         checks++; if ((bus0.o_mem_rd & bus0.o_mem_wr) !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overlap[%0d]: got rd=%b wr=%b expected not both", i, bus0.o_mem_rd, bus0.o_mem_wr); end
         if (expRd[i] || expWr[i]) begin
            checks++; if (bus0.o_mem_addr !== expAddr[i]) begin failures++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", i, bus0.o_mem_addr, expAddr[i]); end
         end
         if (i == 0) begin
            checks++; if (bus0.o_mem_wdata !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_wdata: got %h expected 3c", bus0.o_mem_wdata); end
         end
         if (i == 1) begin
            checks++; if (bus0.o_rdata !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_write_rdata: got %h expected a5", bus0.o_rdata); end
         end
         if (i == 3 || i == 5) begin
            checks++; if (bus0.o_rdata !== 8'h77) begin failures++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected 77", i, bus0.o_rdata); end
         end
         if (expAck[i][2]) bus0.i_s5_req = 1'b0;
         if (expAck[i][1]) bus0.i_s3_req = 1'b0;
         if (expAck[i][0]) bus0.i_s2_req = 1'b0;
      end
   endtask

   task automatic test_wait_states();
      bus3.i_mem_ready = 1'b1;
      bus3.i_mem_rdata = 8'h5A;
      bus3.i_s3_addr   = 16'h0456;
      bus3.i_s3_req    = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++; if (bus3.o_mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL wait_rd[%0d]: got %b expected 1", i, bus3.o_mem_rd); end
         checks++; if (bus3.o_s3_ack !== 1'b0) begin failures++; $display("[TB] FAIL wait_early_ack[%0d]: got %b expected 0", i, bus3.o_s3_ack); end
         checks++; if (bus3.o_mem_addr !== 16'h0456) begin failures++; $display("[TB] FAIL wait_addr[%0d]: got %h expected 0456", i, bus3.o_mem_addr); end
      end
      step();
      checks++; if (bus3.o_s3_ack !== 1'b1) begin failures++; $display("[TB] FAIL wait_ack: got %b expected 1", bus3.o_s3_ack); end
      checks++; if (bus3.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL wait_rd_drop: got %b expected 0", bus3.o_mem_rd); end
      checks++; if (bus3.o_rdata !== 8'h5A) begin failures++; $display("[TB] FAIL wait_rdata: got %h expected 5a", bus3.o_rdata); end
      bus3.i_s3_req = 1'b0;
      step();
      checks++; if (bus3.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL wait_stall_end: got %b expected 0", bus3.o_stall); end
   endtask

   task automatic test_ready_stall();
      bus0.i_mem_ready = 1'b0;
      bus0.i_mem_rdata = 8'hEE;
      bus0.i_s5_addr   = 16'h1A2B;
      bus0.i_s5_wdata  = 8'hC3;
      bus0.i_s5_req    = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++; if (bus0.o_mem_wr !== 1'b1) begin failures++; $display("[TB] FAIL hold_wr[%0d]: got %b expected 1", i, bus0.o_mem_wr); end
         checks++; if (bus0.o_mem_addr !== 16'h1A2B) begin failures++; $display("[TB] FAIL hold_addr[%0d]: got %h expected 1a2b", i, bus0.o_mem_addr); end
         checks++; if (bus0.o_mem_wdata !== 8'hC3) begin failures++; $display("[TB] FAIL hold_wdata[%0d]: got %h expected c3", i, bus0.o_mem_wdata); end
         checks++; if (bus0.o_s5_ack !== 1'b0) begin failures++; $display("[TB] FAIL hold_ack[%0d]: got %b expected 0", i, bus0.o_s5_ack); end
         bus0.i_s5_addr  = 16'h9000 + 16'(i);
         bus0.i_s5_wdata = 8'(i);
         if (i == 10) bus0.i_mem_ready = 1'b1;
      end
      step();
      checks++; if (bus0.o_s5_ack !== 1'b1) begin failures++; $display("[TB] FAIL hold_done_ack: got %b expected 1", bus0.o_s5_ack); end
      checks++; if (bus0.o_mem_wr !== 1'b0) begin failures++; $display("[TB] FAIL hold_wr_drop: got %b expected 0", bus0.o_mem_wr); end
      checks++; if (bus0.o_rdata !== 8'h77) begin failures++; $display("[TB] FAIL hold_rdata_kept: got %h expected 77", bus0.o_rdata); end
      bus0.i_s5_req = 1'b0;
      step();
      checks++; if (bus0.o_s5_ack !== 1'b0) begin failures++; $display("[TB] FAIL hold_ack_pulse: got %b expected 0", bus0.o_s5_ack); end
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL hold_stall_end: got %b expected 0", bus0.o_stall); end
   endtask

   task automatic test_reset_mid_access();
      bus0.i_mem_ready = 1'b0;
      bus0.i_mem_rdata = 8'h99;
      bus0.i_s2_addr   = 16'h0BEE;
      bus0.i_s2_req    = 1'b1;
      step();
      checks++; if (bus0.o_mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_rd_before: got %b expected 1", bus0.o_mem_rd); end
      #2 rstN = 1'b0;
      #1;
      checks++; if (bus0.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_rd: got %b expected 0", bus0.o_mem_rd); end
      checks++; if (bus0.o_mem_addr !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mid_addr: got %h expected 0000", bus0.o_mem_addr); end
      checks++; if (bus0.o_mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_wdata: got %h expected 00", bus0.o_mem_wdata); end
      checks++; if (bus0.o_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_rdata: got %h expected 00", bus0.o_rdata); end
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stall: got %b expected 0", bus0.o_stall); end
      step(); step();
      checks++; if (bus0.o_s2_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_ack: got %b expected 0", bus0.o_s2_ack); end
      rstN = 1'b1;
      bus0.i_mem_ready = 1'b1;
      step();
      checks++; if (bus0.o_mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL rst_restart_rd: got %b expected 1", bus0.o_mem_rd); end
      checks++; if (bus0.o_mem_addr !== 16'h0BEE) begin failures++; $display("[TB] FAIL rst_restart_addr: got %h expected 0bee", bus0.o_mem_addr); end
      step();
      checks++; if (bus0.o_s2_ack !== 1'b1) begin failures++; $display("[TB] FAIL rst_restart_ack: got %b expected 1", bus0.o_s2_ack); end
      checks++; if (bus0.o_rdata !== 8'h99) begin failures++; $display("[TB] FAIL rst_restart_rdata: got %h expected 99", bus0.o_rdata); end
      bus0.i_s2_req = 1'b0;
      step();
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_restart_stall: got %b expected 0", bus0.o_stall); end
   endtask

`ifdef MC8051_MEM_TIMEOUT_EN
   task automatic test_timeout();
      bus0.i_mem_ready = 1'b0;
      bus0.i_mem_rdata = 8'h12;
      bus0.i_s2_addr   = 16'h0777;
      bus0.i_s2_req    = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++; if (bus0.o_mem_rd !== 1'b1) begin failures++; $display("[TB] FAIL to_rd[%0d]: got %b expected 1", i, bus0.o_mem_rd); end
         checks++; if ({bus0.o_s2_ack, bus0.o_err} !== 2'b00) begin failures++; $display("[TB] FAIL to_early[%0d]: got %b expected 00", i, {bus0.o_s2_ack, bus0.o_err}); end
      end
      step();
      checks++; if (bus0.o_s2_ack !== 1'b1) begin failures++; $display("[TB] FAIL to_ack: got %b expected 1", bus0.o_s2_ack); end
      checks++; if (bus0.o_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err: got %b expected 1", bus0.o_err); end
      checks++; if (bus0.o_rdata !== 8'hFF) begin failures++; $display("[TB] FAIL to_rdata: got %h expected ff", bus0.o_rdata); end
      checks++; if (bus0.o_mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL to_rd_drop: got %b expected 0", bus0.o_mem_rd); end
      bus0.i_s2_req = 1'b0;
      step();
      checks++; if (bus0.o_err !== 1'b0) begin failures++; $display("[TB] FAIL to_err_pulse: got %b expected 0", bus0.o_err); end
      checks++; if (bus0.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL to_stall_end: got %b expected 0", bus0.o_stall); end
   endtask
`endif

   // Scenario sequence
   initial begin
      init_inputs();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_wait_states();
      test_ready_stall();
      test_reset_mid_access();
`ifdef MC8051_MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
